// File: rtl/gumnut_data_mem.sv
// Data-memory responder for the Gumnut core: byte RAM with a registered one-cycle ack.
// Ack rises WAIT_STATES enabled edges after the request sample edge; cen=0 freezes everything.
module gumnut_data_mem #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              data_cyc_i,
  input  logic              data_stb_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_adr_i,
  input  logic [7:0]        data_dat_i,
  output logic [7:0]        data_dat_o,
  output logic              data_ack_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] adr_q;
  logic              we_q;
  logic [7:0]        dat_q;
  logic [7:0]        mem [2**ADDR_W];

  logic              acc_go;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_adr;
  logic [7:0]        acc_dat;

  // With no wait states the access happens on the sample edge itself, so it
  // must use the live bus values rather than the not-yet-loaded request regs.
  always_comb begin
    acc_go  = 1'b0;
    acc_we  = we_q;
    acc_adr = adr_q;
    acc_dat = dat_q;
    if (state == ST_IDLE) begin
      acc_go  = data_cyc_i && data_stb_i && (WAIT_STATES == 0);
      acc_we  = data_we_i;
      acc_adr = data_adr_i;
      acc_dat = data_dat_i;
    end else if (state == ST_WAIT) begin
      acc_go = data_cyc_i && (cnt == 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && cen && acc_go && acc_we) begin
      mem[acc_adr] <= acc_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      data_ack_o <= 1'b0;
      data_dat_o <= 8'h00;
    end else if (cen) begin
      case (state)
        ST_IDLE: begin
          if (data_cyc_i && data_stb_i) begin
            adr_q <= data_adr_i;
            we_q  <= data_we_i;
            dat_q <= data_dat_i;
            cnt   <= CNT_INIT;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!data_cyc_i) begin
            state <= ST_IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ACK: begin
          state      <= ST_IDLE;
          data_ack_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
      if (acc_go) begin
        state      <= ST_ACK;
        data_ack_o <= 1'b1;
        if (!acc_we) begin
          data_dat_o <= mem[acc_adr];
        end
      end
    end
  end

endmodule

// File: tb/tb_gumnut_data_mem.sv
// Bench for gumnut_data_mem: three instances (1, 3 and 0 wait states) driven
// by bus tasks and checked against a transaction-level memory model.
module tb_gumnut_data_mem;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen   [NDUT];
  logic       cyc   [NDUT];
  logic       stb   [NDUT];
  logic       we    [NDUT];
  logic [7:0] adr   [NDUT];
  logic [7:0] dat   [NDUT];
  logic [7:0] dat_o [NDUT];
  logic       ack   [NDUT];

  logic [7:0] mem_m    [NDUT][256];
  bit         wr_m     [NDUT][256];
  logic [7:0] last_dat [NDUT];

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    gumnut_data_mem #(
      .ADDR_W(8),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 3 : 0))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cen       (cen[g]),
      .data_cyc_i(cyc[g]),
      .data_stb_i(stb[g]),
      .data_we_i (we[g]),
      .data_adr_i(adr[g]),
      .data_dat_i(dat[g]),
      .data_dat_o(dat_o[g]),
      .data_ack_o(ack[g])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One complete access, started and finished at a negedge.
  task automatic access(input int k, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input string tag);
    int n;
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dat[k] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        adr[k] = 8'($urandom);
        dat[k] = 8'($urandom);
      end
    end while (!ack[k] && n < 40);
    check({tag, "_lat"}, n, ws_of(k) + 1);
    if (w) begin
      mem_m[k][a] = d;
      wr_m[k][a]  = 1'b1;
      check({tag, "_wr_dat_hold"}, dat_o[k], last_dat[k]);
    end else begin
      check({tag, "_rd_dat"}, dat_o[k], mem_m[k][a]);
      last_dat[k] = mem_m[k][a];
    end
    cyc[k] = 1'b0; stb[k] = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, ack[k], 1'b0);
  endtask

  // Starts a request, abandons it after two edges (abort or reset), then
  // counts any ack over the following cycles.
  task automatic dropped(input int k, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic by_rst, input string tag);
    int acks;
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dat[k] = d;
    repeat (2) @(negedge clk);
    cyc[k] = 1'b0; stb[k] = 1'b0;
    if (by_rst) rst = 1'b1;
    acks = 0;
    @(negedge clk);
    rst = 1'b0;
    if (ack[k]) acks++;
    repeat (8) begin
      @(negedge clk);
      if (ack[k]) acks++;
    end
    check({tag, "_no_ack"}, acks, 0);
    if (by_rst) begin
      check({tag, "_dat_clr"}, dat_o[k], 8'h00);
      for (int j = 0; j < NDUT; j++) last_dat[j] = 8'h00;
    end
  endtask

  initial begin
    int n, t_prev;
    logic [7:0] a, d;
    logic w;

    for (int k = 0; k < NDUT; k++) begin
      cen[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      adr[k] = 8'h00; dat[k] = 8'h00; last_dat[k] = 8'h00;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_ack%0d", k), ack[k], 1'b0);
      check($sformatf("rst_dat%0d", k), dat_o[k], 8'h00);
    end
    rst = 1'b0;
    @(negedge clk);

    // RAM survives reset
    access(0, 1'b1, 8'h05, 8'h3C, "pre5");
    access(0, 1'b0, 8'h05, 8'h00, "pre5_rd");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_ack", ack[0], 1'b0);
    check("rst2_dat", dat_o[0], 8'h00);
    rst = 1'b0;
    last_dat[0] = 8'h00;
    access(0, 1'b0, 8'h05, 8'h00, "keep5");

    // write then read, every wait-state setting
    for (int k = 0; k < NDUT; k++) begin
      access(k, 1'b1, 8'h10, 8'hA5, $sformatf("wr10_%0d", k));
      access(k, 1'b0, 8'h10, 8'h00, $sformatf("rd10_%0d", k));
    end

    // abort in WAIT (3 wait states): neither read nor write may take effect
    access(1, 1'b1, 8'h40, 8'h5A, "ab_pre");
    dropped(1, 1'b0, 8'h40, 8'h00, 1'b0, "ab_rd");
    dropped(1, 1'b1, 8'h40, 8'hC3, 1'b0, "ab_wr");
    access(1, 1'b0, 8'h40, 8'h00, "ab_chk");

    // back-to-back reads with stb held
    access(0, 1'b1, 8'h00, 8'h11, "bb_w0");
    access(0, 1'b1, 8'h01, 8'h22, "bb_w1");
    access(0, 1'b1, 8'h02, 8'h33, "bb_w2");
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 8'h00;
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ack[0] && n < 40);
      check($sformatf("bb_ack%0d", i), ack[0], 1'b1);
      check($sformatf("bb_dat%0d", i), dat_o[0], mem_m[0][i]);
      if (i > 0) check($sformatf("bb_gap%0d", i), cycle - t_prev, ws_of(0) + 2);
      t_prev = cycle;
      adr[0] = 8'(i + 1);
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    last_dat[0] = mem_m[0][2];
    @(negedge clk);
    check("bb_pulse", ack[0], 1'b0);

    // cen gating in WAIT and during ACK
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 8'h10;
    @(negedge clk);
    n = 1;
    cen[1] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n++;
    end
    cen[1] = 1'b1;
    while (!ack[1] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("cen_lat", n, ws_of(1) + 1 + 4);
    check("cen_dat", dat_o[1], 8'hA5);
    cen[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("cen_hold%0d", i), ack[1], 1'b1);
    end
    cen[1] = 1'b1;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    last_dat[1] = 8'hA5;
    @(negedge clk);
    check("cen_release", ack[1], 1'b0);

    // reset during WAIT of a write
    access(1, 1'b1, 8'h20, 8'h6E, "rm_pre");
    dropped(1, 1'b1, 8'h20, 8'hFF, 1'b1, "rm");
    access(1, 1'b0, 8'h20, 8'h00, "rm_chk");

    // randomized traffic against the model
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 30; i++) begin
        a = 8'($urandom_range(0, 15));
        w = !wr_m[k][a] || ($urandom_range(0, 1) == 1);
        d = 8'($urandom);
        access(k, w, a, d, $sformatf("rnd%0d_%0d", k, i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
